// File: rtl/taillight_sequencer.sv
// Tail-light sequencer: key synchronizers, turn-side latch, mode register,
// step prescaler and combinational lamp-pattern decode for six tail LEDs.
module taillight_sequencer #(
    parameter int TICK_DIV = 25_000_000,
    parameter int CNT_W    = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       SW,
    input  logic [1:0]       K,
    output logic [2:0]       state,
    output logic             turn_side_r,
    output logic [5:0]       LED
);

    typedef enum logic [2:0] {
        IDLE       = 3'b000,
        HAZARDS    = 3'b001,
        TURN_LEFT  = 3'b010,
        TURN_RIGHT = 3'b011
    } state_t;

    state_t           cur;
    state_t           nxt;
    logic [1:0]       phase;
    logic [1:0]       phase_nxt;
    logic [CNT_W-1:0] presc;
    logic [CNT_W-1:0] presc_nxt;
    logic             presc_wrap;
    logic             tick;
    logic [1:0]       k_s1;
    logic [1:0]       k_s2;
    logic [1:0]       k_prev;
    logic [1:0]       fall;
    logic             side_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur         <= IDLE;
            phase       <= 2'd0;
            presc       <= '0;
            turn_side_r <= 1'b0;
            k_s1        <= 2'b11;
            k_s2        <= 2'b11;
            k_prev      <= 2'b11;
        end else begin
            cur         <= nxt;
            phase       <= phase_nxt;
            presc       <= presc_nxt;
            turn_side_r <= side_nxt;
            k_s1        <= K;
            k_s2        <= k_s1;
            k_prev      <= k_s2;
        end
    end

    always_comb begin
        fall       = k_prev & ~k_s2;
        side_nxt   = turn_side_r;
        nxt        = IDLE;
        phase_nxt  = phase;
        presc_nxt  = presc;
        tick       = 1'b0;
        presc_wrap = (presc == CNT_W'(TICK_DIV - 1));

        // Simultaneous presses cancel out and leave the latch alone.
        if (fall == 2'b01) begin
            side_nxt = 1'b0;
        end else if (fall == 2'b10) begin
            side_nxt = 1'b1;
        end

        if (SW[0]) begin
            nxt = HAZARDS;
        end else if (SW[1]) begin
            nxt = turn_side_r ? TURN_RIGHT : TURN_LEFT;
        end else begin
            nxt = IDLE;
        end

        // A mode change restarts the pattern and suppresses any tick that lands on it.
        if (nxt != cur) begin
            phase_nxt = 2'd0;
            presc_nxt = '0;
        end else begin
            presc_nxt = presc_wrap ? '0 : presc + CNT_W'(1);
            tick      = presc_wrap;
        end

        if (tick) begin
            case (cur)
                HAZARDS:    phase_nxt = {1'b0, ~phase[0]};
                TURN_LEFT,
                TURN_RIGHT: phase_nxt = phase + 2'd1;
                default:    phase_nxt = 2'd0;
            endcase
        end
    end

    always_comb begin
        LED = 6'b000_000;
        case (cur)
            HAZARDS: LED = phase[0] ? 6'b000_000 : 6'b111_111;
            TURN_LEFT: begin
                case (phase)
                    2'd0:    LED = 6'b000_000;
                    2'd1:    LED = 6'b001_000;
                    2'd2:    LED = 6'b011_000;
                    default: LED = 6'b111_000;
                endcase
            end
            TURN_RIGHT: begin
                case (phase)
                    2'd0:    LED = 6'b000_000;
                    2'd1:    LED = 6'b000_100;
                    2'd2:    LED = 6'b000_110;
                    default: LED = 6'b000_111;
                endcase
            end
            default: LED = 6'b000_000;
        endcase
    end

    assign state = cur;

endmodule
